fft_pingpong_buf: RTL and testbench
===================================

FFT_PINGPONG_BUF -- requirements
Module: fft_pingpong_buf

Interface
REQ-001 Parameter DATA_W, default 16: width of each real and imaginary sample component.
REQ-002 Parameter N_LOG2, default 3: log2 of the frame length N, so the default is N=8 points.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  input sample present.
REQ-006 in_ready  output  1  buffer can accept an input sample.
REQ-007 in_re, in_im  input  DATA_W each  input sample, real and imaginary parts.
REQ-008 in_abort  input  1  synchronous: discard the partially written frame.
REQ-009 out_valid  output  1  output sample present.
REQ-010 out_ready  input  1  downstream accepts the output sample.
REQ-011 out_re, out_im  output  DATA_W each  output sample, real and imaginary parts.
REQ-012 out_idx  output  N_LOG2  buffer address of the current output sample.
REQ-013 out_last  output  1  current output sample is the final sample of its frame.
REQ-014 busy  output  1  high when either bank is full or the write count is nonzero.

Function
REQ-015 Storage: two banks (bank 0, bank 1) of N complex entries each, built from flops; per-bank full flag; write pointers wr_bank/wr_cnt; read pointers rd_bank/rd_cnt.
REQ-016 in_ready = !full[wr_bank]; an input transfer is in_valid && in_ready, and it writes the sample to entry wr_cnt of bank wr_bank.
REQ-017 Write completion: a transfer with wr_cnt==N-1 sets full[wr_bank], toggles wr_bank and resets wr_cnt to 0; any other transfer increments wr_cnt.
REQ-018 out_valid = full[rd_bank]; the first sample of a frame is valid the cycle after the write transfer that completed that frame.
REQ-019 out_re/out_im are read combinationally from entry out_idx of bank rd_bank; an output transfer is out_valid && out_ready.
REQ-020 Read completion: a transfer with rd_cnt==N-1 clears full[rd_bank], toggles rd_bank and resets rd_cnt to 0; any other transfer increments rd_cnt.
REQ-021 out_last = out_valid && (rd_cnt==N-1).
REQ-022 While out_valid && !out_ready, out_re, out_im, out_idx and out_last are held stable.
REQ-023 A write completion and a read completion in the same cycle, on different banks, both take effect.
REQ-024 Steady state: with in_valid and out_ready held high, both ports sustain 1 sample/cycle with no bubbles after the first frame.
REQ-025 When both banks are full, in_ready=0 until a read completion frees a bank; no sample is lost or overwritten.
REQ-026 in_abort sets wr_cnt to 0 and takes priority over a same-cycle input transfer; that sample is dropped. Full banks, the read side and wr_bank are unaffected.
REQ-027 Counters wrap modulo N; wr_bank and rd_bank wrap modulo 2.

Reset
REQ-028 While rst_n=0: full flags=0, wr_bank=rd_bank=0, wr_cnt=rd_cnt=0. This gives in_ready=1, out_valid=0, out_last=0, out_idx=0, busy=0.
REQ-029 Bank contents are not reset; out_re/out_im are don't-care while out_valid=0.
REQ-030 Reset mid-frame discards all buffered and partial frames; operation resumes from the REQ-028 state on the first edge after rst_n deasserts.

Configuration
REQ-031 Macro FFT_BUF_BITREV_EN defined: out_idx = bit-reversal of rd_cnt over N_LOG2 bits, so frames are output in bit-reversed order.
REQ-032 Macro FFT_BUF_BITREV_EN undefined: out_idx = rd_cnt, so frames are output in natural order; interface and timing are identical in both cases.

Verification (N=8, DATA_W=16)
REQ-033 Write samples re=0..7, im=0, then hold out_ready=1 -> with BITREV: out_re 0,4,2,6,1,5,3,7 and out_last only on the 8th; without BITREV: 0..7.
REQ-034 Continuous stream of 4 frames, in_valid=out_ready=1 throughout -> zero bubbles after the first frame; out_valid first rises the cycle after input sample 8.
REQ-035 out_ready=0 while 16 samples are offered -> in_ready falls after the 16th sample is accepted and the 17th is not accepted; set out_ready=1 -> in_ready returns the cycle after out_last.
REQ-036 Write 5 samples, pulse in_abort together with a 6th, then write 8 more -> the output frame is exactly those 8 samples.
REQ-037 Assert rst_n=0 mid-read (rd_cnt=3) -> out_valid=0 and in_ready=1 immediately, with no clock edge needed.
REQ-038 Hold out_ready=0 for 3 cycles at rd_cnt=2 -> outputs stay constant, then the sequence continues without skipping or repeating a sample.

Source files
------------

// File: rtl/fft_pingpong_buf.sv
// fft_pingpong_buf: two-bank ping-pong frame buffer that sits between a
// streaming complex-sample source and an FFT stage. One bank fills while the
// other drains, so both ports sustain one sample per cycle in steady state.
// Configuration macro FFT_BUF_BITREV_EN: when defined, frames are read out in
// bit-reversed address order; when undefined, in natural order.
module fft_pingpong_buf #(
    parameter int DATA_W = 16,
    parameter int N_LOG2 = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_re,
    input  logic signed [DATA_W-1:0] in_im,
    input  logic                     in_abort,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_re,
    output logic signed [DATA_W-1:0] out_im,
    output logic [N_LOG2-1:0]        out_idx,
    output logic                     out_last,
    output logic                     busy
);
    localparam int N = 1 << N_LOG2;
    localparam logic [N_LOG2-1:0] CNT_MAX = N_LOG2'(N - 1);

    // Sample storage: bank index first, then entry address. Never reset.
    logic signed [DATA_W-1:0] mem_re [2][N];
    logic signed [DATA_W-1:0] mem_im [2][N];

    logic [1:0]        full;
    logic              wr_bank;
    logic              rd_bank;
    logic [N_LOG2-1:0] wr_cnt;
    logic [N_LOG2-1:0] rd_cnt;

    logic wr_fire;
    logic wr_done;
    logic rd_fire;
    logic rd_done;

`ifdef FFT_BUF_BITREV_EN
    function automatic logic [N_LOG2-1:0] bit_rev(input logic [N_LOG2-1:0] v);
        logic [N_LOG2-1:0] r;
        r = '0;
        for (int i = 0; i < N_LOG2; i++) begin
            r[i] = v[N_LOG2-1-i];
        end
        return r;
    endfunction
`endif

    // Handshakes, read addressing and status derived from the bank pointers.
    always_comb begin
        in_ready  = !full[wr_bank];
        out_valid = full[rd_bank];
        // An abort drops the sample offered in the same cycle.
        wr_fire   = in_valid && in_ready && !in_abort;
        wr_done   = wr_fire && (wr_cnt == CNT_MAX);
        rd_fire   = out_valid && out_ready;
        rd_done   = rd_fire && (rd_cnt == CNT_MAX);
        out_last  = out_valid && (rd_cnt == CNT_MAX);
        busy      = (|full) || (wr_cnt != '0);
`ifdef FFT_BUF_BITREV_EN
        out_idx   = bit_rev(rd_cnt);
`else
        out_idx   = rd_cnt;
`endif
        out_re    = mem_re[rd_bank][out_idx];
        out_im    = mem_im[rd_bank][out_idx];
    end

    // Control state: fill/drain pointers and per-bank full flags. A write
    // completion and a read completion always target different banks, so
    // both flag updates can land in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full    <= 2'b00;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
        end else begin
            if (in_abort) begin
                wr_cnt <= '0;
            end else if (wr_fire) begin
                if (wr_done) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                    wr_cnt        <= '0;
                end else begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
            end
            if (rd_fire) begin
                if (rd_done) begin
                    full[rd_bank] <= 1'b0;
                    rd_bank       <= ~rd_bank;
                    rd_cnt        <= '0;
                end else begin
                    rd_cnt <= rd_cnt + 1'b1;
                end
            end
        end
    end

    // Sample write into the filling bank; data path carries no reset.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_re[wr_bank][wr_cnt] <= in_re;
            mem_im[wr_bank][wr_cnt] <= in_im;
        end
    end

endmodule

// File: tb/tb_fft_pingpong_buf.sv
// tb_fft_pingpong_buf: bench for fft_pingpong_buf (N=8, DATA_W=16), built
// with or without FFT_BUF_BITREV_EN. A frame-level queue model predicts the
// outputs every cycle; directed scenarios pin the model with literal values.
module tb_fft_pingpong_buf;
    localparam int DATA_W = 16;
    localparam int N_LOG2 = 3;
    localparam int N      = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic in_abort = 1'b0;
    logic out_ready = 1'b0;
    logic signed [DATA_W-1:0] in_re = '0;
    logic signed [DATA_W-1:0] in_im = '0;
    logic in_ready;
    logic out_valid;
    logic out_last;
    logic busy;
    logic signed [DATA_W-1:0] out_re;
    logic signed [DATA_W-1:0] out_im;
    logic [N_LOG2-1:0] out_idx;

    int n_pass = 0;
    int n_total = 0;

`ifdef FFT_BUF_BITREV_EN
    int ord_tab [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
    int ord_tab [8] = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif

    always #5 clk = ~clk;

    fft_pingpong_buf #(.DATA_W(DATA_W), .N_LOG2(N_LOG2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_re(in_re), .in_im(in_im), .in_abort(in_abort),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im), .out_idx(out_idx),
        .out_last(out_last), .busy(busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: completed frames queued back to back, partial frame separately,
    // plus the read position within the oldest completed frame.
    logic [2*DATA_W-1:0] done_q[$];
    logic [2*DATA_W-1:0] part_q[$];
    int rd_pos = 0;
    int cap[$];
    bit m_valid, m_ready, m_busy, m_last, m_wr, m_rd;
    int m_idx;

    function automatic int model_idx(input int p);
`ifdef FFT_BUF_BITREV_EN
        int r = 0;
        for (int i = 0; i < N_LOG2; i++) if (((p >> i) & 1) != 0) r |= 1 << (N_LOG2 - 1 - i);
        return r;
`else
        return p;
`endif
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            done_q.delete();
            part_q.delete();
            rd_pos = 0;
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 1);
            chk("rst_busy", busy, 0);
            chk("rst_out_last", out_last, 0);
            chk("rst_out_idx", out_idx, 0);
        end else begin
            m_valid = done_q.size() >= N;
            m_ready = done_q.size() < 2 * N;
            m_busy  = m_valid || (part_q.size() > 0);
            m_last  = m_valid && (rd_pos == N - 1);
            m_idx   = model_idx(rd_pos);
            chk("in_ready", in_ready, m_ready);
            chk("out_valid", out_valid, m_valid);
            chk("busy", busy, m_busy);
            chk("out_last", out_last, m_last);
            chk("out_idx", out_idx, m_idx);
            if (m_valid) chk("out_data", {out_re, out_im}, done_q[m_idx]);
            if (out_valid && out_ready) cap.push_back(int'(out_re));
            m_wr = in_valid && m_ready && !in_abort;
            m_rd = m_valid && out_ready;
            if (in_abort) begin
                part_q.delete();
            end else if (m_wr) begin
                part_q.push_back({in_re, in_im});
                if (part_q.size() == N) begin
                    foreach (part_q[k]) done_q.push_back(part_q[k]);
                    part_q.delete();
                end
            end
            if (m_rd) begin
                rd_pos++;
                if (rd_pos == N) begin
                    rd_pos = 0;
                    repeat (N) void'(done_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int re, input int im);
        in_valid = 1'b1;
        in_re = DATA_W'(re);
        in_im = DATA_W'(im);
        tick();
    endtask

    int acc;
    int bub;
    bit found;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Natural vs bit-reversed order of a ramp frame.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) put(i, 0);
        in_valid = 1'b0;
        cap.delete();
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("A_last", out_last, k == 7);
            tick();
        end
        chk("A_count", cap.size(), 8);
        for (int k = 0; k < 8 && k < cap.size(); k++) chk("A_order", cap[k], ord_tab[k]);

        // Stall for three cycles at read position 2.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) put(10 + i, -i);
        in_valid = 1'b0;
        cap.delete();
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("B_hold_re", out_re, 10 + ord_tab[2]);
            chk("B_hold_idx", out_idx, ord_tab[2]);
            tick();
        end
        out_ready = 1'b1;
        repeat (8) tick();
        chk("B_count", cap.size(), 8);
        for (int k = 0; k < 8 && k < cap.size(); k++) chk("B_order", cap[k], 10 + ord_tab[k]);

        // Back-pressure: both banks fill, then one frees after out_last.
        out_ready = 1'b0;
        in_valid = 1'b1;
        acc = 0;
        for (int c = 0; c < 20; c++) begin
            in_re = DATA_W'($urandom);
            in_im = DATA_W'($urandom);
            @(negedge clk);
            if (in_ready) acc++;
            tick();
        end
        chk("C_accepted", acc, 16);
        @(negedge clk);
        chk("C_ready_low", in_ready, 0);
        tick();
        out_ready = 1'b1;
        found = 1'b0;
        for (int t = 0; t < 40 && !found; t++) begin
            @(negedge clk);
            if (out_last) begin
                found = 1'b1;
                chk("C_ready_at_last", in_ready, 0);
            end
            tick();
        end
        chk("C_last_seen", found, 1);
        @(negedge clk);
        chk("C_ready_back", in_ready, 1);
        tick();
        in_valid = 1'b0;
        in_abort = 1'b1;
        tick();
        in_abort = 1'b0;
        repeat (30) tick();

        // Abort discards the partial frame and the sample offered with it.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) put(200 + i, 1);
        in_abort = 1'b1;
        put(299, 1);
        in_abort = 1'b0;
        for (int i = 0; i < 8; i++) put(300 + i, 2);
        in_valid = 1'b0;
        cap.delete();
        out_ready = 1'b1;
        repeat (10) tick();
        chk("D_count", cap.size(), 8);
        for (int k = 0; k < 8 && k < cap.size(); k++) chk("D_order", cap[k], 300 + ord_tab[k]);
        @(negedge clk);
        chk("D_busy_idle", busy, 0);
        tick();

        // Continuous stream of four frames.
        cap.delete();
        out_ready = 1'b1;
        bub = 0;
        acc = 0;
        for (int i = 0; i < 32; i++) begin
            in_valid = 1'b1;
            in_re = DATA_W'(400 + i);
            in_im = DATA_W'(i);
            @(negedge clk);
            if (i == 7) chk("E_not_yet", out_valid, 0);
            if (i == 8) chk("E_first_valid", out_valid, 1);
            if (i >= 8 && !out_valid) bub++;
            if (!in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (!out_valid) bub++;
            tick();
        end
        chk("E_bubbles", bub, 0);
        chk("E_in_stalls", acc, 0);
        chk("E_count", cap.size(), 32);
        for (int k = 0; k < 32 && k < cap.size(); k++)
            chk("E_order", cap[k], 400 + (k / 8) * 8 + ord_tab[k % 8]);

        // Randomized traffic with occasional aborts.
        for (int c = 0; c < 800; c++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            in_abort  = ($urandom % 40) == 0;
            in_re = DATA_W'($urandom);
            in_im = DATA_W'($urandom);
            tick();
        end
        in_valid = 1'b0;
        in_abort = 1'b1;
        tick();
        in_abort = 1'b0;
        out_ready = 1'b1;
        repeat (20) tick();

        // Asynchronous reset in the middle of a read.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) put(500 + i, 3);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("G_valid_async", out_valid, 0);
        chk("G_ready_async", in_ready, 1);
        chk("G_busy_async", busy, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) put(600 + i, 4);
        in_valid = 1'b0;
        repeat (12) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
